// File: rtl/truth_table_sweeper_if.sv
// ---------------------------------------------------------------------------
// truth_table_sweeper_if
//   Bundles the sweep handshake and the data seen by the truth-table sweeper.
//   The control/stimulus side (bench or top-level FSM, plus the block under
//   exercise that returns f_in) uses the master modport. The sweeper itself
//   uses the slave modport.
//
//   Signals:
//     start        sweep request (accepted only while the sweeper is idle)
//     f_in         output of the combinational block under exercise
//     exp_table    expected truth table, bit i = expected f for vector i
//     x_out        input vector driven to the block
//     busy         high while a sweep is running
//     done         one-cycle completion pulse
//     table_out    captured truth table, bit i = f_in sampled for vector i
//     mismatch_cnt number of bits where table_out differs from exp_table
//     first_fail   lowest failing vector index
//     fail         at least one mismatch
// ---------------------------------------------------------------------------
interface truth_table_sweeper_if #(
    parameter int N_IN = 4
);
    localparam int NV = 1 << N_IN;

    logic            start;
    logic            f_in;
    logic [NV-1:0]   exp_table;
    logic [N_IN-1:0] x_out;
    logic            busy;
    logic            done;
    logic [NV-1:0]   table_out;
    logic [N_IN:0]   mismatch_cnt;
    logic [N_IN-1:0] first_fail;
    logic            fail;

    modport master (
        output start, f_in, exp_table,
        input  x_out, busy, done, table_out, mismatch_cnt, first_fail, fail
    );

    modport slave (
        input  start, f_in, exp_table,
        output x_out, busy, done, table_out, mismatch_cnt, first_fail, fail
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// ---------------------------------------------------------------------------
// truth_table_sweeper
//   Walks an N_IN-input combinational block through all 2^N_IN input vectors
//   in ascending order. Each vector is held for SETTLE+1 cycles and f_in is
//   sampled on the last edge of that window into table_out.
//
//   Optional feature (macro SWEEP_COMPARE_EN): when defined, the captured
//   table is compared with exp_table as the sweep finishes, producing
//   mismatch_cnt, first_fail and fail. When undefined those outputs are tied
//   to 0 and exp_table is ignored.
//
//   Ports:
//     clk  - single clock, rising edge
//     rst  - synchronous active-high reset
//     bus  - truth_table_sweeper_if.slave (start/f_in/exp_table in,
//            x_out/busy/done/table_out/compare results out)
// ---------------------------------------------------------------------------
module truth_table_sweeper #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    truth_table_sweeper_if.slave  bus
);
    localparam int NV = 1 << N_IN;
    // Settle counter only needs to reach SETTLE; keep at least one bit.
    localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [CW-1:0]   SETTLE_C = CW'(SETTLE);
    localparam logic [N_IN-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [N_IN-1:0] r_idx;
    logic [CW-1:0]   r_cnt;
    logic [N_IN-1:0] r_x_out;
    logic            r_busy;
    logic            r_done;
    logic [NV-1:0]   r_table;

    logic w_sample;
    logic w_last_vec;

    assign w_sample   = (r_cnt == SETTLE_C);
    assign w_last_vec = (r_idx == LAST_IDX);

`ifdef SWEEP_COMPARE_EN
    logic [N_IN:0]   r_mcnt;
    logic [N_IN-1:0] r_first_fail;
    logic            r_fail;

    // Final table as it will look after the closing sample, so the compare
    // result is available in the same cycle as done.
    logic [NV-1:0]   w_final_table;
    logic [NV-1:0]   w_diff;
    logic [N_IN:0]   w_pop;
    logic [N_IN-1:0] w_lowest;

    genvar gi;
    generate
        for (gi = 0; gi < NV; gi++) begin : g_diff
            assign w_final_table[gi] = (r_idx == N_IN'(gi)) ? bus.f_in : r_table[gi];
            assign w_diff[gi]        = w_final_table[gi] ^ bus.exp_table[gi];
        end
    endgenerate

    // Scan from the top down so the last assignment leaves the lowest index.
    always_comb begin
        w_pop    = '0;
        w_lowest = '0;
        for (int i = NV - 1; i >= 0; i--) begin
            if (w_diff[i]) begin
                w_pop    = w_pop + (N_IN + 1)'(1);
                w_lowest = N_IN'(i);
            end
        end
    end

    assign bus.mismatch_cnt = r_mcnt;
    assign bus.first_fail   = r_first_fail;
    assign bus.fail         = r_fail;
`else
    logic w_unused_exp;
    assign w_unused_exp     = ^bus.exp_table;
    assign bus.mismatch_cnt = '0;
    assign bus.first_fail   = '0;
    assign bus.fail         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_x_out <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_table <= '0;
`ifdef SWEEP_COMPARE_EN
            r_mcnt       <= '0;
            r_first_fail <= '0;
            r_fail       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_x_out <= '0;
                    if (bus.start) begin
                        r_table <= '0;
                        r_idx   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
`ifdef SWEEP_COMPARE_EN
                        r_mcnt       <= '0;
                        r_first_fail <= '0;
                        r_fail       <= 1'b0;
`endif
                    end
                end

                S_RUN: begin
                    if (!w_sample) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        r_table[r_idx] <= bus.f_in;
                        r_cnt          <= '0;
                        if (w_last_vec) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_x_out <= '0;
                            r_state <= S_DONE;
`ifdef SWEEP_COMPARE_EN
                            r_mcnt       <= w_pop;
                            r_first_fail <= w_lowest;
                            r_fail       <= (w_pop != '0);
`endif
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_x_out <= r_idx + 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.x_out     = r_x_out;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.table_out = r_table;
endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

- Sequencer for the lab's small combinational function blocks.
- Drives an N-input block through all 2^N input vectors in ascending order, waits a programmable settle time per vector, and samples the block's single output into a truth-table register.
- Replaces hand-written per-vector stimulus with one start/done handshake.
- Sits between a control source (bench or top-level FSM) and the combinational block under exercise.

## Interface

Parameters:
- N_IN, 4, number of function inputs; x_out[N_IN-1] maps to x1 (MSB), x_out[0] maps to the last input.
- SETTLE, 1, extra wait cycles per vector before sampling; 0 is legal.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  sweep request; accepted only in IDLE.
- f_in  in  1  output of the combinational block.
- exp_table  in  2^N_IN  expected truth table, bit i = expected f for vector i; used only with SWEEP_COMPARE_EN.
- x_out  out  N_IN  vector driven to the block.
- busy  out  1  high while a sweep is in RUN.
- done  out  1  one-cycle pulse when the sweep completes.
- table_out  out  2^N_IN  captured truth table, bit i = f_in sampled for vector i.
- mismatch_cnt  out  N_IN+1  count of bits where table_out differs from exp_table.
- first_fail  out  N_IN  lowest failing vector index.
- fail  out  1  at least one mismatch.

## Operation

- FSM states: IDLE, RUN, DONE.
- Internal registers: vector index idx (N_IN bits) and settle counter cnt (wide enough to hold SETTLE).
- **IDLE**
  - busy=0, done=0, x_out=0.
  - On start=1: clear table_out and the compare outputs, set idx=0 and cnt=0, go to RUN.
- **RUN**
  - busy=1; x_out=idx (registered).
  - Each edge with cnt<SETTLE: cnt++.
  - Edge with cnt==SETTLE: table_out[idx]<=f_in and cnt<=0.
    - If idx==2^N_IN-1: go to DONE.
    - Otherwise: idx++.
- **DONE**
  - done=1 and busy=0 for exactly one cycle, then return to IDLE.
- start is ignored in RUN and DONE; no queuing.
- table_out holds its value after DONE until the next accepted start.
- idx does not wrap past 2^N_IN-1; the last sample always ends the sweep.

## Timing

- Reset values: state=IDLE; x_out=0, busy=0, done=0, table_out=0, mismatch_cnt=0, first_fail=0, fail=0.
- Sweep length:
  - Start is accepted at edge E0.
  - busy is high for 2^N_IN·(SETTLE+1) cycles after E0.
  - done is high in the cycle that follows.
  - Example: N_IN=4, SETTLE=1 gives 32 busy cycles, with done in cycle 33 after E0.
- Each vector is presented for SETTLE+1 cycles. f_in is sampled on the last edge of that window, so the block has at least SETTLE+1 cycles of combinational settle from the x_out update.
- rst asserted mid-sweep: on the next edge, all outputs return to reset values and the FSM returns to IDLE. No done pulse is produced.
- rst and start high in the same cycle: reset wins.
- start held high continuously: a new sweep begins in the cycle after DONE, with one IDLE cycle between sweeps.

## Configuration

- Macro: SWEEP_COMPARE_EN.
- **Defined**
  - On the DONE transition edge: mismatch_cnt = popcount(table_out ^ exp_table), computed on the final table including the last sample.
  - first_fail = lowest set bit index of that XOR.
  - fail = (mismatch_cnt != 0).
  - All three are valid while done=1 and hold until the next start.
- **Undefined**
  - exp_table is ignored.
  - mismatch_cnt, first_fail and fail are tied to 0.
  - No comparison logic is synthesized.
  - Ports remain present.

## Test plan

- Stub f_in = x_out[3] & x_out[0], N_IN=4, SETTLE=1, pulse start → 32 busy cycles, then done for 1 cycle; table_out=16'hAA00; x_out steps 0..15, each value held 2 cycles.
- f_in tied to 1, SETTLE=0 → busy for 16 cycles; table_out=16'hFFFF; done one cycle later.
- SWEEP_COMPARE_EN, stub as first scenario, exp_table=16'hAA01 → mismatch_cnt=1, first_fail=0, fail=1 while done=1. With exp_table=16'hAA00 → mismatch_cnt=0, fail=0.
- Pulse start again at cycle 10 of a running sweep → ignored; sweep length unchanged; exactly one done pulse.
- Assert rst at cycle 12 of a sweep → next cycle busy=0, x_out=0, table_out=0, no done; a fresh start afterward completes normally with the correct table.
- Hold start high across two sweeps → done pulses separated by exactly 2^N_IN·(SETTLE+1)+2 cycles; second table_out matches the first.
